// File: rtl/wb_stream_writer.sv
// wb_stream_writer: Wishbone burst-read DMA into a FWFT FIFO feeding a valid/ready stream (optional irq via WB_STREAM_WRITER_IRQ_EN)
module wb_stream_writer #(
    parameter int WB_DW         = 32,
    parameter int WB_AW         = 32,
    parameter int FIFO_AW       = 4,
    parameter int MAX_BURST_LEN = 2**FIFO_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [WB_AW-1:0]   wbm_adr_o,
    output logic [WB_DW-1:0]   wbm_dat_o,
    output logic [WB_DW/8-1:0] wbm_sel_o,
    output logic               wbm_we_o,
    output logic               wbm_cyc_o,
    output logic               wbm_stb_o,
    output logic [2:0]         wbm_cti_o,
    output logic [1:0]         wbm_bte_o,
    input  logic [WB_DW-1:0]   wbm_dat_i,
    input  logic               wbm_ack_i,
    input  logic               wbm_err_i,
    input  logic               wbm_rty_i,
    output logic [WB_DW-1:0]   stream_data,
    output logic               stream_dv,
    input  logic               stream_ready,
    input  logic [WB_AW-1:0]   wbs_adr_i,
    input  logic [WB_DW-1:0]   wbs_dat_i,
    input  logic [WB_DW/8-1:0] wbs_sel_i,
    input  logic               wbs_we_i,
    input  logic               wbs_cyc_i,
    input  logic               wbs_stb_i,
    input  logic [2:0]         wbs_cti_i,
    input  logic [1:0]         wbs_bte_i,
    output logic [WB_DW-1:0]   wbs_dat_o,
    output logic               wbs_ack_o,
    output logic               wbs_err_o,
    output logic               wbs_rty_o,
    output logic               irq
);
    localparam int DEPTH = 2**FIFO_AW;

    typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;
    state_t state, state_nx;

    logic               enable, done, err;
    logic [WB_AW-1:0]   start_adr, adr;
    logic [WB_DW-1:0]   buf_size, burst_size, remaining, len, beat, burst_clamp, len_calc, rd_data;
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt, free;
    logic [WB_DW-1:0]   mem [DEPTH];
    logic               load, start, push, pop, set_done, set_err, clr_en, last, cfg_acc, cfg_wr;
    logic               unused;

    assign unused      = ^{wbs_adr_i, wbs_dat_i, wbs_sel_i, wbs_cti_i, wbs_bte_i, wbm_rty_i};
    assign cfg_acc     = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
    assign cfg_wr      = cfg_acc & wbs_we_i;
    assign free        = (FIFO_AW+1)'(DEPTH) - cnt;
    assign burst_clamp = burst_size == '0 ? WB_DW'(1) :
                         burst_size > WB_DW'(MAX_BURST_LEN) ? WB_DW'(MAX_BURST_LEN) : burst_size;
    assign len_calc    = remaining < burst_clamp ? remaining : burst_clamp;
    assign last        = beat == len - WB_DW'(1);
    assign pop         = stream_dv & stream_ready;

    assign wbm_cyc_o   = state == BURST;
    assign wbm_stb_o   = wbm_cyc_o;
    assign wbm_cti_o   = wbm_cyc_o ? (last ? 3'b111 : 3'b010) : 3'b000;
    assign wbm_bte_o   = 2'b00;
    assign wbm_we_o    = 1'b0;
    assign wbm_dat_o   = '0;
    assign wbm_sel_o   = {(WB_DW/8){wbm_cyc_o}};
    assign wbm_adr_o   = adr;
    assign stream_dv   = cnt != '0;
    assign stream_data = stream_dv ? mem[rd_ptr] : '0;
    assign wbs_err_o   = 1'b0;
    assign wbs_rty_o   = 1'b0;
`ifdef WB_STREAM_WRITER_IRQ_EN
    assign irq         = done | err;
`else
    assign irq         = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state and control strobes; the FIFO slot check in WAIT guarantees every beat of a burst fits
    always_comb begin
        state_nx = state;
        load     = 1'b0;
        start    = 1'b0;
        push     = 1'b0;
        set_done = 1'b0;
        set_err  = 1'b0;
        clr_en   = 1'b0;
        case (state)
            IDLE: if (enable) begin
                if (buf_size == '0) begin
                    set_done = 1'b1;
                    clr_en   = 1'b1;
                end else begin
                    load     = 1'b1;
                    state_nx = WAIT;
                end
            end
            WAIT: if (!enable) state_nx = IDLE;
                  else if (WB_DW'(free) >= len_calc) begin
                      start    = 1'b1;
                      state_nx = BURST;
                  end
            BURST: if (wbm_err_i) begin
                set_err  = 1'b1;
                clr_en   = 1'b1;
                state_nx = IDLE;
            end else if (wbm_ack_i) begin
                push = 1'b1;
                if (last) state_nx = remaining == WB_DW'(1) ? DONE : enable ? WAIT : IDLE;
            end
            DONE: begin
                set_done = 1'b1;
                clr_en   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Transfer address, remaining word count and per-burst beat tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adr       <= '0;
            remaining <= '0;
            len       <= '0;
            beat      <= '0;
        end else begin
            if (load) begin
                adr       <= start_adr;
                remaining <= buf_size;
            end
            if (start) begin
                len  <= len_calc;
                beat <= '0;
            end
            if (push) begin
                adr       <= adr + WB_AW'(WB_DW/8);
                remaining <= remaining - WB_DW'(1);
                beat      <= beat + WB_DW'(1);
            end
        end
    end

    // Register readback mux
    always_comb begin
        rd_data = wbs_adr_i[3:2] == 2'd0 ? WB_DW'({err, done, enable}) :
                  wbs_adr_i[3:2] == 2'd1 ? WB_DW'(start_adr) :
                  wbs_adr_i[3:2] == 2'd2 ? buf_size : burst_size;
    end

    // Config slave: single-cycle ack, register writes, W1C status; FSM events override CPU writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbs_ack_o  <= 1'b0;
            wbs_dat_o  <= '0;
            enable     <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            start_adr  <= '0;
            buf_size   <= '0;
            burst_size <= '0;
        end else begin
            wbs_ack_o <= cfg_acc;
            if (cfg_acc) wbs_dat_o <= rd_data;
            if (cfg_wr && wbs_adr_i[3:2] == 2'd0) begin
                enable <= wbs_dat_i[0];
                done   <= ~wbs_dat_i[0] & done & ~wbs_dat_i[1];
                err    <= ~wbs_dat_i[0] & err & ~wbs_dat_i[2];
            end
            if (cfg_wr && !enable && wbs_adr_i[3:2] == 2'd1) start_adr  <= WB_AW'(wbs_dat_i);
            if (cfg_wr && !enable && wbs_adr_i[3:2] == 2'd2) buf_size   <= wbs_dat_i;
            if (cfg_wr && !enable && wbs_adr_i[3:2] == 2'd3) burst_size <= wbs_dat_i;
            if (set_done) done   <= 1'b1;
            if (set_err)  err    <= 1'b1;
            if (clr_en)   enable <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide even when full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            cnt <= cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
        end
    end

    // FIFO storage, written on each acknowledged beat
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wbm_dat_i;
    end
endmodule

// File: tb/tb_wb_stream_writer.sv
// tb_wb_stream_writer: randomized directed bench for wb_stream_writer with a transfer-level reference model
module tb_wb_stream_writer;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i = '0, stream_data, wbs_adr_i = '0, wbs_dat_i = '0, wbs_dat_o;
    logic [3:0]  wbm_sel_o, wbs_sel_i = 4'hf;
    logic [2:0]  wbm_cti_o, wbs_cti_i = '0;
    logic [1:0]  wbm_bte_o, wbs_bte_i = '0;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i = 0, wbm_err_i = 0, wbm_rty_i = 0;
    logic        stream_dv, stream_ready = 0, wbs_we_i = 0, wbs_cyc_i = 0, wbs_stb_i = 0;
    logic        wbs_ack_o, wbs_err_o, wbs_rty_o, irq;

    int checks = 0, failures = 0;
    int ready_mode = 1, rty_left = 0, err_beat = -1, beat_cnt = 0;
    bit err_seen = 0;
    logic [31:0] exp_adr[$], exp_data[$], ctrl, rd;
    logic [2:0]  exp_cti[$];
    logic [31:0] sa;
    int          size, bs;
`ifdef WB_STREAM_WRITER_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    wb_stream_writer dut (
        .clk(clk), .rst_n(rst_n),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o), .wbm_we_o(wbm_we_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
        .stream_data(stream_data), .stream_dv(stream_dv), .stream_ready(stream_ready),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i), .wbs_we_i(wbs_we_i),
        .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_cti_i(wbs_cti_i), .wbs_bte_i(wbs_bte_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o), .wbs_rty_o(wbs_rty_o),
        .irq(irq)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: burst split and word stream from the transfer rules, truncated at stop_at acked beats
    task automatic build(input logic [31:0] a, input int n, input int b, input int stop_at);
        int rem = n, off = 0, l;
        exp_adr.delete(); exp_cti.delete(); exp_data.delete();
        while (rem > 0) begin
            l = b < 1 ? 1 : b;
            if (l > 16) l = 16;
            if (l > rem) l = rem;
            for (int j = 0; j < l; j++) begin
                if (off < stop_at) begin
                    exp_adr.push_back(a + 32'(4 * off));
                    exp_cti.push_back(j == l - 1 ? 3'b111 : 3'b010);
                    exp_data.push_back(word(a + 32'(4 * off)));
                end
                off++;
            end
            rem -= l;
        end
    endtask

    task automatic cfg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        wbs_adr_i = {28'b0, a, 2'b0}; wbs_dat_i = d; wbs_we_i = 1; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(negedge clk);
        chk("cfg_wr_ack", {31'b0, wbs_ack_o}, 1);
        wbs_we_i = 0; wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic cfg_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        wbs_adr_i = {28'b0, a, 2'b0}; wbs_we_i = 0; wbs_cyc_i = 1; wbs_stb_i = 1;
        @(negedge clk);
        chk("cfg_rd_ack", {31'b0, wbs_ack_o}, 1);
        d = wbs_dat_o;
        wbs_cyc_i = 0; wbs_stb_i = 0;
    endtask

    task automatic run(input logic [31:0] a, input int n, input int b, input int stop_at);
        build(a, n, b, stop_at);
        cfg_wr(2'd1, a); cfg_wr(2'd2, 32'(n)); cfg_wr(2'd3, 32'(b));
        beat_cnt = 0;
        cfg_wr(2'd0, 32'h1);
    endtask

    task automatic wait_idle(input string tag, output logic [31:0] c);
        int n = 0;
        do begin cfg_rd(2'd0, c); n++; end while (c[0] && n < 2000);
        chk({tag, "_finish_in_time"}, 32'(n < 2000), 1);
        n = 0;
        while (exp_data.size() > 0 && n < 3000) begin @(negedge clk); n++; end
        chk({tag, "_words_left"}, 32'(exp_data.size()), 0);
        chk({tag, "_beats_left"}, 32'(exp_adr.size()), 0);
    endtask

    // Wishbone memory slave, beat checker and stream consumer, all acting on the falling edge
    always @(negedge clk) begin
        wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = '0;
        if (err_seen) begin chk("err_cyc_drop", {31'b0, wbm_cyc_o}, 0); err_seen = 0; end
        if (rst_n && wbm_cyc_o && wbm_stb_o) begin
            if (rty_left > 0) begin
                wbm_rty_i = 1; rty_left--;
                chk("rty_adr_hold", wbm_adr_o, exp_adr.size() > 0 ? exp_adr[0] : 'x);
            end else if (beat_cnt == err_beat) begin
                wbm_err_i = 1; err_seen = 1; err_beat = -1;
            end else begin
                wbm_ack_i = 1; wbm_dat_i = word(wbm_adr_o);
                chk("beat_adr", wbm_adr_o, exp_adr.size() > 0 ? exp_adr[0] : 'x);
                chk("beat_cti", {29'b0, wbm_cti_o}, exp_cti.size() > 0 ? {29'b0, exp_cti[0]} : 'x);
                if (exp_adr.size() > 0) begin void'(exp_adr.pop_front()); void'(exp_cti.pop_front()); end
                beat_cnt++;
            end
        end
        stream_ready = ready_mode == 2 ? 1'($urandom_range(0, 1)) : ready_mode == 1;
        if (rst_n && stream_dv && stream_ready) begin
            chk("stream_word", stream_data, exp_data.size() > 0 ? exp_data[0] : 'x);
            if (exp_data.size() > 0) void'(exp_data.pop_front());
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_cyc", {31'b0, wbm_cyc_o}, 0);
        chk("rst_stb", {31'b0, wbm_stb_o}, 0);
        chk("rst_cti", {29'b0, wbm_cti_o}, 0);
        chk("rst_dv", {31'b0, stream_dv}, 0);
        chk("rst_irq", {31'b0, irq}, 0);
        chk("rst_adr", wbm_adr_o, 0);
        rst_n = 1;
        for (int r = 0; r < 4; r++) begin cfg_rd(2'(r), rd); chk("rst_reg", rd, 0); end

        ready_mode = 1;
        run(32'h1000, 8, 4, 8);
        @(negedge clk); chk("latency_stb_low", {31'b0, wbm_stb_o}, 0);
        @(negedge clk); chk("latency_stb_high", {31'b0, wbm_stb_o}, 1);
        wait_idle("basic", ctrl);
        chk("basic_ctrl", ctrl, 32'h2);
        chk("basic_irq", {31'b0, irq}, {31'b0, IRQ_EN});
        cfg_wr(2'd0, 32'h2);
        cfg_rd(2'd0, rd); chk("w1c_done", rd, 0);
        chk("w1c_irq", {31'b0, irq}, 0);

        run(32'h2000, 5, 4, 5);
        wait_idle("five_four", ctrl);
        chk("five_four_ctrl", ctrl, 32'h2);
        chk("five_four_beats", 32'(beat_cnt), 5);

        ready_mode = 0;
        run(32'h3000, 32, 8, 32);
        repeat (200) @(negedge clk);
        chk("bp_fetched", 32'(beat_cnt), 16);
        chk("bp_stb_idle", {31'b0, wbm_stb_o}, 0);
        chk("bp_dv", {31'b0, stream_dv}, 1);
        cfg_wr(2'd1, 32'hDEAD0000);
        cfg_rd(2'd1, rd); chk("locked_start_adr", rd, 32'h3000);
        ready_mode = 2;
        wait_idle("backpressure", ctrl);
        chk("bp_ctrl", ctrl, 32'h2);

        ready_mode = 1;
        err_beat = 1;
        run(32'h4000, 8, 4, 1);
        wait_idle("err", ctrl);
        chk("err_ctrl", ctrl, 32'h4);
        chk("err_irq", {31'b0, irq}, {31'b0, IRQ_EN});
        chk("err_beats", 32'(beat_cnt), 1);

        rty_left = 3;
        run(32'h5000, 4, 4, 4);
        wait_idle("rty", ctrl);
        chk("rty_ctrl", ctrl, 32'h2);
        chk("rty_left", 32'(rty_left), 0);

        run(32'h6000, 0, 4, 0);
        wait_idle("zero_size", ctrl);
        chk("zero_size_ctrl", ctrl, 32'h2);

        for (int t = 0; t < 5; t++) begin
            sa = $urandom & 32'hFFFF_FFFC;
            size = $urandom_range(1, 40);
            bs = $urandom_range(0, 20);
            ready_mode = 2;
            run(sa, size, bs, size);
            wait_idle("random", ctrl);
            chk("random_ctrl", ctrl, 32'h2);
            chk("random_beats", 32'(beat_cnt), 32'(size));
        end

        ready_mode = 0;
        run(32'h7000, 32, 8, 32);
        n = 0;
        while (!wbm_cyc_o && n < 50) begin @(negedge clk); n++; end
        chk("arst_burst_seen", {31'b0, wbm_cyc_o}, 1);
        @(posedge clk); #2;
        rst_n = 0;
        exp_adr.delete(); exp_cti.delete(); exp_data.delete();
        #1;
        chk("arst_cyc", {31'b0, wbm_cyc_o}, 0);
        chk("arst_stb", {31'b0, wbm_stb_o}, 0);
        chk("arst_dv", {31'b0, stream_dv}, 0);
        chk("arst_adr", wbm_adr_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        for (int r = 0; r < 4; r++) begin cfg_rd(2'(r), rd); chk("arst_reg", rd, 0); end
        repeat (5) @(negedge clk);
        chk("arst_quiet", {31'b0, wbm_cyc_o}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wb_stream_writer.md
# wb_stream_writer

Memory-to-stream DMA: reads a buffer from system memory with Wishbone incrementing-burst reads, buffers the words in an internal first-word-fall-through FIFO, and presents them on a valid/ready stream output. Counterpart of the stream-to-memory path; sits between the system Wishbone interconnect (master side), the CPU configuration bus (slave side) and a streaming consumer (e.g. DAC, video or UART TX engine).

## Interface
- WB_DW, 32, Wishbone and stream data width
- WB_AW, 32, Wishbone address width; addresses are byte addresses
- FIFO_AW, 4, FIFO depth = 2**FIFO_AW words
- MAX_BURST_LEN, 2**FIFO_AW, upper clamp on burst length in words

- clk  in  1  single clock for all logic
- rst_n  in  1  reset, asynchronous assert, active-low
- wbm_adr_o / wbm_dat_o / wbm_sel_o / wbm_we_o  out  WB_AW / WB_DW / WB_DW/8 / 1  master; dat_o=0, sel_o all ones, we_o=0
- wbm_cyc_o, wbm_stb_o  out  1  master cycle/strobe
- wbm_cti_o  out  3  010 during burst, 111 on final beat
- wbm_bte_o  out  2  always 00 (linear)
- wbm_dat_i  in  WB_DW  read data; wbm_ack_i, wbm_err_i, wbm_rty_i  in  1
- stream_data  out  WB_DW  FIFO head word
- stream_dv  out  1  stream_data valid (FIFO non-empty)
- stream_ready  in  1  consumer accepts word when dv&ready
- wbs_adr_i in WB_AW, wbs_dat_i in WB_DW, wbs_sel_i in WB_DW/8, wbs_we_i/wbs_cyc_i/wbs_stb_i in 1, wbs_cti_i in 3, wbs_bte_i in 2  config slave
- wbs_dat_o  out  WB_DW; wbs_ack_o, wbs_err_o, wbs_rty_o  out  1  (err/rty tied 0)
- irq  out  1  completion/error interrupt (see Configuration)

## Operation
- Registers (wbs_adr_i[3:2]): 0 CTRL (bit0 enable, bit1 done, bit2 err); 1 START_ADR; 2 BUF_SIZE (words); 3 BURST_SIZE (words). Reset: all 0.
- START_ADR/BUF_SIZE/BURST_SIZE writes ignored while enable=1. done/err are write-1-to-clear; writing enable=1 clears done and err.
- Effective burst length L = min(max(BURST_SIZE,1), MAX_BURST_LEN, remaining words).
- FSM: IDLE -> (enable & BUF_SIZE!=0) load adr=START_ADR, remaining=BUF_SIZE -> WAIT. enable with BUF_SIZE=0 -> done=1, enable cleared.
- WAIT: when free = 2**FIFO_AW - fifo_cnt >= L (fifo_cnt FIFO_AW+1 bits) -> BURST, assert cyc/stb next cycle.
- BURST: each ack pushes wbm_dat_i into FIFO, adr += WB_DW/8, remaining -= 1, beat += 1. cti=111 when beat==L-1. After last ack: cyc/stb drop; remaining==0 -> DONE else WAIT.
- rty: beat not counted, strobe held. err: cycle terminated immediately, err=1, enable cleared -> IDLE; FIFO contents kept and still drain.
- DONE: done=1, enable cleared -> IDLE. Clearing enable mid-burst: current burst completes, then IDLE.
- Stream: stream_dv = FIFO non-empty; pop on stream_dv & stream_ready. Push and pop in same cycle allowed, including at full (space was reserved, so no overflow).

## Timing
- All outputs 0 in reset (cti 000); async clear aborts any cycle immediately.
- Config slave: ack 1 cycle after cyc&stb, single-cycle pulse, read data valid with ack.
- Enable write to first wbm_stb_o: 2 cycles when FIFO has space.
- Ack-to-stream_dv: 1 cycle (FWFT, data registered on push).
- Zero gap between consecutive ack'd beats within a burst; ≥1 idle cycle between bursts.

## Configuration
- WB_STREAM_WRITER_IRQ_EN defined: irq = done | err (level, cleared by W1C). Undefined: irq tied 0, CTRL bit1/bit2 still readable.

## Test plan
- START_ADR=0x1000, BUF_SIZE=8, BURST_SIZE=4, ready=1 -> two bursts at 0x1000 and 0x1010, cti 010,010,010,111; 8 words streamed in order; done=1, irq=1.
- stream_ready=0, FIFO_AW=4, BUF_SIZE=32, BURST_SIZE=8 -> exactly 16 words fetched, no further stb until ready raised; no lost or duplicated words.
- BUF_SIZE=5, BURST_SIZE=4 -> bursts of 4 then 1; single-beat burst has cti=111.
- err on beat 2 of burst -> cyc drops same cycle+1, err=1, enable=0, 1 prior word still streamed.
- rst_n low mid-burst -> cyc/stb/stream_dv 0 asynchronously, all registers 0.
- rty on beat 0 for 3 cycles -> stb held, adr unchanged, burst then completes normally.
